po_duty_ctrl: RTL and testbench
===============================

// Module: po_duty_ctrl
// PURPOSE
//  Sequential core of the open-loop P&O MPPT loop. It latches each new power sample and keeps the
//  previous sample and the previous criterion, which together drive the combinational criterion stage.
//  It consumes the new criterion, steps the converter duty cycle with saturation, and emits the PWM.
//  It sits between the power-measurement front end (upstream) and the gate driver (downstream).
// PARAMETERS
//  PW      12    power sample width (matches criterion stage)
//  DW      12    duty / PWM counter width; PWM period = 2**DW clk
//  STEP    16    duty increment/decrement per P&O iteration (LSB of duty)
//  D_MIN   205   lower duty clamp (~5%)
//  D_MAX   3890  upper duty clamp (~95%)
//  D_INIT  2048  duty after reset (50%)
//  SETTLE  1000  clk cycles to wait after a duty change before accepting a sample (>=1)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous reset, active-high
//  en         in   1   loop enable; 0 = hold duty, PWM low
//  sample_vld in   1   1-cycle strobe: pot_in valid
//  pot_in     in   PW  measured power from front end
//  cri_i      in   1   new criterion from criterion stage (combinational from pot_act/pot_ant/cri)
//  pot_act    out  PW  registered current sample -> criterion stage
//  pot_ant    out  PW  registered previous sample -> criterion stage
//  cri        out  1   registered criterion (1 = increase duty) -> criterion stage
//  duty       out  DW  current commanded duty
//  pwm        out  1   gate drive
//  sat        out  1   duty sits at D_MIN or D_MAX
//  busy       out  1   high in SETTLE and EVAL
// BEHAVIOUR
//  Reset (async): state=IDLE, pot_act=0, pot_ant=0, cri=1, duty=D_INIT, duty_act=D_INIT,
//   pwm_cnt=0, pwm=0, sat=0, busy=0, first=1, settle_cnt=0.
//  FSM: IDLE -(en)-> SETTLE -(settle_cnt==SETTLE-1)-> WAITS -(sample_vld)-> EVAL -> SETTLE.
//   In any state, en=0 -> IDLE next cycle; duty, pot_act, pot_ant and cri are held; first is not changed.
//   In IDLE -> SETTLE, settle_cnt is cleared.
//  WAITS: on sample_vld, pot_act<=pot_in. sample_vld is ignored in every other state (no queueing).
//  EVAL (exactly 1 cycle; cri_i is stable because pot_act, pot_ant and cri are all registered):
//   first=1: pot_ant<=pot_act, first<=0, duty and cri unchanged (no valid previous sample).
//   first=0: cri<=cri_i; pot_ant<=pot_act; duty<=sat(cri_i ? duty+STEP : duty-STEP).
//   Arithmetic is done in DW+1 signed bits; a result >D_MAX clamps to D_MAX and <D_MIN clamps to D_MIN.
//   sat is registered with duty.
//  Latency: sample_vld to the new duty = 2 clk. The new duty reaches pwm at the next PWM wrap.
//  PWM: pwm_cnt is a free-running DW-bit counter that wraps 2**DW-1 -> 0.
//   duty_act<=duty only when pwm_cnt==2**DW-1, so the PWM is glitch-free.
//   pwm = en & (pwm_cnt < duty_act), registered.
//  Boundaries:
//   duty==D_MAX and cri_i=1 -> stays at D_MAX, sat=1. At D_MIN it mirrors this.
//   duty change coinciding with the wrap cycle -> duty_act takes the value duty held before that edge.
//   sample_vld with en=0 in the same cycle -> ignored.
//   rst mid-EVAL -> all registers take their reset values; nothing partial persists.
// STRUCTURE
//  Shared package (mppt_pkg): PW, DW, the D_MIN/D_MAX/D_INIT/STEP defaults, FSM state localparams.
//  One natural sub-module: pwm_gen (counter, shadow duty_act, compare). FSM and registers stay in this module.
//  The criterion stage is instantiated beside this block at top level, not inside it.
// TESTING (SETTLE=4, STEP=16 in the bench)
//  1 reset: rst pulse -> duty=2048, cri=1, pot_act=pot_ant=0, pwm=0, busy=0.
//  2 first sample: en=1, then after settle pot_in=100 -> pot_ant=100, duty stays 2048, cri stays 1.
//  3 rising power: next sample 120 with a stub for cri_i -> cri=1, duty=2064 two clk after the strobe,
//    pwm duty_act=2064 from the next wrap.
//  4 falling power with cri=1: sample 90 -> cri=0, duty=2048; then sample 80 -> cri=1, duty=2064.
//  5 clamp: preload duty near 3880 and force cri_i=1 twice -> 3890, 3890, sat=1; mirror the test at D_MIN=205.
//  6 en drop mid-SETTLE and strobe during SETTLE: no duty change, pwm=0 while en=0;
//    async rst during EVAL -> immediate reset values.

Source files
------------

// File: rtl/mppt_pkg.sv
// Shared definitions for the P&O MPPT duty controller: default widths,
// duty limits and the FSM state encoding.
package mppt_pkg;

  localparam int PW_DEF     = 12;
  localparam int DW_DEF     = 12;
  localparam int STEP_DEF   = 16;
  localparam int D_MIN_DEF  = 205;
  localparam int D_MAX_DEF  = 3890;
  localparam int D_INIT_DEF = 2048;
  localparam int SETTLE_DEF = 1000;

  // IDLE: loop disabled; SETTLE: converter settling after a duty change;
  // WAITS: waiting for a power sample; EVAL: one-cycle decision step
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_WAITS  = 2'd2,
    ST_EVAL   = 2'd3
  } state_e;

  // True when a duty value sits exactly on one of the clamp limits
  function automatic logic at_limit(input int value, input int lo, input int hi);
    return (value == lo) || (value == hi);
  endfunction

endpackage

// File: rtl/po_duty_ctrl_pwm_gen.sv
// PWM generator: free-running counter, shadow duty register reloaded only
// at the counter wrap, and a registered compare output.
module pwm_gen
  import mppt_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int D_INIT = D_INIT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] duty,
  output logic          pwm
);

  localparam logic [DW-1:0] CNT_LAST = '1;

  logic [DW-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [DW-1:0] duty_act_q, duty_act_d;
  logic          pwm_q, pwm_d;

  // Next-state: count, reload the shadow duty at the end of a period so a
  // new duty never lands mid-period, and compare against the shadow copy
  always_comb begin
    pwm_cnt_d  = pwm_cnt_q + DW'(1);
    duty_act_d = duty_act_q;
    if (pwm_cnt_q == CNT_LAST) begin
      duty_act_d = duty;
    end
    pwm_d = en & (pwm_cnt_q < duty_act_q);
  end

  // PWM registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q  <= '0;
      duty_act_q <= DW'(D_INIT);
      pwm_q      <= 1'b0;
    end else begin
      pwm_cnt_q  <= pwm_cnt_d;
      duty_act_q <= duty_act_d;
      pwm_q      <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/po_duty_ctrl.sv
// Sequential core of the P&O MPPT loop: latches power samples, holds the
// previous sample and criterion for the external criterion stage, steps the
// duty cycle with saturation and drives the PWM generator.
module po_duty_ctrl
  import mppt_pkg::*;
#(
  parameter int PW     = PW_DEF,
  parameter int DW     = DW_DEF,
  parameter int STEP   = STEP_DEF,
  parameter int D_MIN  = D_MIN_DEF,
  parameter int D_MAX  = D_MAX_DEF,
  parameter int D_INIT = D_INIT_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          sample_vld,
  input  logic [PW-1:0] pot_in,
  input  logic          cri_i,
  output logic [PW-1:0] pot_act,
  output logic [PW-1:0] pot_ant,
  output logic          cri,
  output logic [DW-1:0] duty,
  output logic          pwm,
  output logic          sat,
  output logic          busy
);

  // Duty arithmetic runs one bit wider and signed so that stepping below
  // zero or past the top is visible before clamping
  localparam int AW  = DW + 1;
  localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic signed [AW-1:0] STEP_S  = AW'(STEP);
  localparam logic signed [AW-1:0] D_MIN_S = AW'(D_MIN);
  localparam logic signed [AW-1:0] D_MAX_S = AW'(D_MAX);
  localparam logic [SCW-1:0]       SETTLE_LAST = SCW'(SETTLE - 1);

  state_e          state_q, state_d;
  logic [SCW-1:0]  settle_cnt_q, settle_cnt_d;
  logic [PW-1:0]   pot_act_q, pot_act_d;
  logic [PW-1:0]   pot_ant_q, pot_ant_d;
  logic            cri_q, cri_d;
  logic [DW-1:0]   duty_q, duty_d;
  logic            sat_q, sat_d;
  logic            first_q, first_d;

  logic signed [AW-1:0] duty_ext;
  logic signed [AW-1:0] duty_step;
  logic signed [AW-1:0] duty_clamp;
  logic [DW-1:0]        duty_next;

  // Candidate duty for this evaluation: step in the criterion direction,
  // then clamp into the allowed operating window
  always_comb begin
    duty_ext  = $signed({1'b0, duty_q});
    duty_step = cri_i ? (duty_ext + STEP_S) : (duty_ext - STEP_S);
    duty_clamp = duty_step;
    if (duty_step > D_MAX_S) begin
      duty_clamp = D_MAX_S;
    end else if (duty_step < D_MIN_S) begin
      duty_clamp = D_MIN_S;
    end
    duty_next = duty_clamp[DW-1:0];
  end

  // FSM next-state and register updates; dropping en from any state parks
  // the loop in IDLE while leaving all tracking registers untouched
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    pot_act_d    = pot_act_q;
    pot_ant_d    = pot_ant_q;
    cri_d        = cri_q;
    duty_d       = duty_q;
    sat_d        = sat_q;
    first_d      = first_q;

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d      = ST_SETTLE;
          settle_cnt_d = '0;
        end
      end

      ST_SETTLE: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (settle_cnt_q == SETTLE_LAST) begin
          state_d = ST_WAITS;
        end else begin
          settle_cnt_d = settle_cnt_q + SCW'(1);
        end
      end

      ST_WAITS: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (sample_vld) begin
          pot_act_d = pot_in;
          state_d   = ST_EVAL;
        end
      end

      ST_EVAL: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else begin
          state_d      = ST_SETTLE;
          settle_cnt_d = '0;
          pot_ant_d    = pot_act_q;
          if (first_q) begin
            first_d = 1'b0;
          end else begin
            cri_d  = cri_i;
            duty_d = duty_next;
            sat_d  = at_limit(int'(duty_next), D_MIN, D_MAX);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and data registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      pot_act_q    <= '0;
      pot_ant_q    <= '0;
      cri_q        <= 1'b1;
      duty_q       <= DW'(D_INIT);
      sat_q        <= 1'b0;
      first_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      pot_act_q    <= pot_act_d;
      pot_ant_q    <= pot_ant_d;
      cri_q        <= cri_d;
      duty_q       <= duty_d;
      sat_q        <= sat_d;
      first_q      <= first_d;
    end
  end

  pwm_gen #(
    .DW     (DW),
    .D_INIT (D_INIT)
  ) u_pwm_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .duty (duty_q),
    .pwm  (pwm)
  );

  assign pot_act = pot_act_q;
  assign pot_ant = pot_ant_q;
  assign cri     = cri_q;
  assign duty    = duty_q;
  assign sat     = sat_q;
  assign busy    = (state_q == ST_SETTLE) || (state_q == ST_EVAL);

endmodule

// File: tb/tb_po_duty_ctrl.sv
// Self-checking bench for po_duty_ctrl: random power samples checked against
// a P&O reference model, plus directed clamp, enable and reset cases.
module tb_po_duty_ctrl;

  localparam int PW     = 12;
  localparam int DW     = 12;
  localparam int STEP   = 16;
  localparam int D_MIN  = 205;
  localparam int D_MAX  = 3890;
  localparam int D_INIT = 2048;
  localparam int SETTLE = 4;
  localparam int PERIOD = 1 << DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          sample_vld = 1'b0;
  logic [PW-1:0] pot_in = '0;
  logic          cri_i;
  logic [PW-1:0] pot_act;
  logic [PW-1:0] pot_ant;
  logic          cri;
  logic [DW-1:0] duty;
  logic          pwm;
  logic          sat;
  logic          busy;

  // 0 = criterion stage stub, 1 = force increase, 2 = force decrease
  int force_mode = 0;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_duty, m_pot_act, m_pot_ant, m_cri, m_sat, m_first;

  // Criterion stage stub: keep direction while power rises, reverse otherwise
  assign cri_i = (force_mode == 1) ? 1'b1 :
                 (force_mode == 2) ? 1'b0 :
                 ((pot_act > pot_ant) ? cri : ~cri);

  always #5 clk = ~clk;

  po_duty_ctrl #(
    .PW(PW), .DW(DW), .STEP(STEP), .D_MIN(D_MIN), .D_MAX(D_MAX),
    .D_INIT(D_INIT), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .sample_vld(sample_vld), .pot_in(pot_in),
    .cri_i(cri_i), .pot_act(pot_act), .pot_ant(pot_ant), .cri(cri),
    .duty(duty), .pwm(pwm), .sat(sat), .busy(busy)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    m_duty = D_INIT; m_pot_act = 0; m_pot_ant = 0; m_cri = 1; m_sat = 0; m_first = 1;
  endtask

  task automatic checkRegs(input string tag);
    checkOutput({tag, "_duty"},    int'(duty),    m_duty);
    checkOutput({tag, "_cri"},     int'(cri),     m_cri);
    checkOutput({tag, "_pot_act"}, int'(pot_act), m_pot_act);
    checkOutput({tag, "_pot_ant"}, int'(pot_ant), m_pot_ant);
    checkOutput({tag, "_sat"},     int'(sat),     m_sat);
  endtask

  // Wait until the controller is settled and accepting a sample
  task automatic waitReady();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy) break;
    end
    for (int i = 0; i < 50; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    checkOutput("ready", int'(busy), 0);
  endtask

  // Model one accepted sample
  task automatic modelSample(input int p);
    int c, nd;
    m_pot_act = p;
    if (m_first == 1) begin
      m_first = 0;
    end else begin
      if (force_mode == 1)      c = 1;
      else if (force_mode == 2) c = 0;
      else                      c = (p > m_pot_ant) ? m_cri : 1 - m_cri;
      nd = m_duty + (c == 1 ? STEP : -STEP);
      if (nd > D_MAX) nd = D_MAX;
      if (nd < D_MIN) nd = D_MIN;
      m_cri  = c;
      m_duty = nd;
      m_sat  = (nd == D_MIN || nd == D_MAX) ? 1 : 0;
    end
    m_pot_ant = p;
  endtask

  // Strobe one sample (controller must be ready) and check the result 2 clk later
  task automatic applyStimulus(input int p);
    sample_vld = 1'b1;
    pot_in     = PW'(p);
    @(negedge clk);
    sample_vld = 1'b0;
    checkOutput("pot_act_latch", int'(pot_act), p);
    modelSample(p);
    @(negedge clk);
    checkRegs("eval");
  endtask

  // Count high cycles across one full period after the shadow duty has reloaded
  task automatic checkPwm(input string tag, input int expected);
    int highs = 0;
    repeat (PERIOD) @(negedge clk);
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge clk);
      if (pwm) highs++;
    end
    checkOutput(tag, highs, expected);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int extra;
    int highs;
    resetModel();

    // Reset values
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkRegs("reset");
    checkOutput("reset_pwm",  int'(pwm),  0);
    checkOutput("reset_busy", int'(busy), 0);

    // First sample only establishes the reference
    en = 1'b1;
    waitReady();
    applyStimulus(100);

    // Rising power, then two falling samples
    waitReady();
    applyStimulus(120);
    checkOutput("rise_duty", int'(duty), 2064);
    checkPwm("pwm_2064", 2064);
    waitReady();
    applyStimulus(90);
    checkOutput("fall1_duty", int'(duty), 2048);
    waitReady();
    applyStimulus(80);
    checkOutput("fall2_duty", int'(duty), 2064);

    // Random power samples through the criterion stub
    for (int k = 0; k < 24; k++) begin
      waitReady();
      applyStimulus(int'($urandom_range(0, PERIOD - 1)));
    end

    // Upper clamp
    force_mode = 1;
    extra = 0;
    for (int k = 0; k < 300 && extra < 3; k++) begin
      waitReady();
      applyStimulus(int'($urandom_range(0, PERIOD - 1)));
      if (m_duty == D_MAX) extra++;
    end
    checkOutput("clamp_hi_duty", int'(duty), D_MAX);
    checkOutput("clamp_hi_sat",  int'(sat),  1);
    checkPwm("pwm_dmax", D_MAX);

    // Lower clamp
    force_mode = 2;
    extra = 0;
    for (int k = 0; k < 300 && extra < 3; k++) begin
      waitReady();
      applyStimulus(int'($urandom_range(0, PERIOD - 1)));
      if (m_duty == D_MIN) extra++;
    end
    checkOutput("clamp_lo_duty", int'(duty), D_MIN);
    checkOutput("clamp_lo_sat",  int'(sat),  1);
    force_mode = 0;

    // Strobe during SETTLE is ignored
    waitReady();
    applyStimulus(int'($urandom_range(0, PERIOD - 1)));
    sample_vld = 1'b1;
    pot_in     = PW'($urandom_range(0, PERIOD - 1));
    @(negedge clk);
    sample_vld = 1'b0;
    @(negedge clk);
    checkRegs("settle_strobe");

    // Enable drop mid-SETTLE with strobes: everything held, pwm low
    waitReady();
    applyStimulus(int'($urandom_range(0, PERIOD - 1)));
    en = 1'b0;
    @(negedge clk);
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      sample_vld = (i % 3 == 0);
      pot_in     = PW'($urandom_range(0, PERIOD - 1));
      @(negedge clk);
      if (pwm) highs++;
    end
    sample_vld = 1'b0;
    checkOutput("en_off_pwm_highs", highs, 0);
    checkOutput("en_off_busy", int'(busy), 0);
    checkRegs("en_off");

    // Resume: the reference is kept, so the next sample steps the duty
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      waitReady();
      applyStimulus(int'($urandom_range(0, PERIOD - 1)));
    end

    // Asynchronous reset while in EVAL
    waitReady();
    sample_vld = 1'b1;
    pot_in     = PW'($urandom_range(1, PERIOD - 1));
    @(negedge clk);
    sample_vld = 1'b0;
    #2 rst = 1'b1;
    #1;
    resetModel();
    checkRegs("rst_eval");
    checkOutput("rst_eval_busy", int'(busy), 0);
    checkOutput("rst_eval_pwm",  int'(pwm),  0);
    @(negedge clk);
    rst = 1'b0;

    // Restart after reset: first sample again only sets the reference
    for (int k = 0; k < 6; k++) begin
      waitReady();
      applyStimulus(int'($urandom_range(0, PERIOD - 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
